// File: rtl/rolfmobile99_uart_tx_if.sv
// rolfmobile99_uart_tx_if: byte handshake between a producer and the UART transmitter.
//   tx_data  [7:0] byte offered by the producer
//   tx_valid       producer has a byte on tx_data
//   tx_ready       transmitter can accept a byte this cycle
interface rolfmobile99_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/rolfmobile99_uart_tx.sv
// rolfmobile99_uart_tx: 8N1 UART transmitter fed by a valid/ready byte handshake.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   s      slave side of the byte handshake (tx_data, tx_valid, tx_ready)
//   tx     registered serial line, idle high
//   busy   registered, high from first start cycle through last stop cycle
module rolfmobile99_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    rolfmobile99_uart_tx_if.slave  s,
    output logic                   tx,
    output logic                   busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    sh, sh_d;
    logic          tx_d, busy_d, last, accept;

    assign last       = cnt == CW'(CLKS_PER_BIT - 1);
    // Ready in the final stop cycle too, so frames can run back to back.
    assign s.tx_ready = (state == IDLE) || (state == STOP && last);
    assign accept     = s.tx_valid && s.tx_ready;

    always_comb begin
        state_d = state;
        cnt_d   = (state == IDLE || last) ? '0 : cnt + CW'(1);
        idx_d   = idx;
        sh_d    = accept ? s.tx_data : sh;
        case (state)
            IDLE:  state_d = accept ? START : IDLE;
            START: state_d = last ? DATA : START;
            DATA: begin
                if (last) begin
                    idx_d   = idx + 3'd1;
                    sh_d    = sh >> 1;
                    state_d = (idx == 3'd7) ? STOP : DATA;
                end
            end
            default: state_d = last ? (accept ? START : IDLE) : STOP;
        endcase
        // Line level is decided from next state so tx is a clean register.
        tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            sh    <= sh_d;
            tx    <= tx_d;
            busy  <= busy_d;
        end
    end
endmodule

// File: tb/tb_rolfmobile99_uart_tx.sv
// tb_rolfmobile99_uart_tx: self-checking bench for the UART transmitter at CLKS_PER_BIT 4 and 2.
module tb_rolfmobile99_uart_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rolfmobile99_uart_tx_if if4 ();
    rolfmobile99_uart_tx_if if2 ();
    logic tx4, busy4, tx2, busy2;

    rolfmobile99_uart_tx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .reset(reset), .s(if4), .tx(tx4), .busy(busy4));
    rolfmobile99_uart_tx #(.CLKS_PER_BIT(2)) dut2 (.clk(clk), .reset(reset), .s(if2), .tx(tx2), .busy(busy2));

    int   total = 0;
    int   bad = 0;
    logic sel2 = 1'b0;
    wire  tx_m    = sel2 ? tx2 : tx4;
    wire  busy_m  = sel2 ? busy2 : busy4;
    wire  ready_m = sel2 ? if2.tx_ready : if4.tx_ready;

    typedef struct {
        logic [7:0] data;
        logic [7:0] alt;
        logic [9:0] frame;
        bit         sel2;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d);
        if (sel2) begin
            if2.tx_valid = v;
            if2.tx_data  = d;
        end else begin
            if4.tx_valid = v;
            if4.tx_data  = d;
        end
    endtask

    // Offer a byte at a negedge; the next posedge accepts it, then data switches to alt.
    task automatic start(input string tag, input logic [7:0] d, input logic [7:0] alt);
        chk({tag, " ready_before_accept"}, ready_m, 1'b1);
        set_in(1'b1, d);
        @(negedge clk);
        set_in(1'b0, alt);
    endtask

    // Check every cycle of a frame; ends on the negedge of its last stop cycle.
    task automatic run_frame(input string tag, input logic [9:0] f, input int cpb, input bit pulse, input int stop_at);
        for (int k = 0; k < 10 * cpb; k++) begin
            if (k == stop_at) return;
            if (k > 0) @(negedge clk);
            if (pulse) set_in(k >= 10 && k <= 20, (k >= 10 && k <= 20) ? 8'h3C : 8'h00);
            chk({tag, " tx"}, tx_m, f[k / cpb]);
            chk({tag, " busy"}, busy_m, 1'b1);
            chk({tag, " ready"}, ready_m, k == 10 * cpb - 1);
        end
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        chk({tag, " idle_tx"}, tx_m, 1'b1);
        chk({tag, " idle_busy"}, busy_m, 1'b0);
        chk({tag, " idle_ready"}, ready_m, 1'b1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h00, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h0F, 8'hF0, 10'b1_00001111_0, 1'b0};
        vecs[2] = '{8'hC3, 8'h3C, 10'b1_11000011_0, 1'b0};
        vecs[3] = '{8'h55, 8'hAA, 10'b1_01010101_0, 1'b0};
        vecs[4] = '{8'h01, 8'hFE, 10'b1_00000001_0, 1'b1};
        vecs[5] = '{8'h80, 8'h7F, 10'b1_10000000_0, 1'b1};
        if4.tx_valid = 1'b0; if4.tx_data = 8'h00;
        if2.tx_valid = 1'b0; if2.tx_data = 8'h00;

        #2 reset = 1'b0;
        #1;
        chk("reset tx4", tx4, 1'b1);
        chk("reset busy4", busy4, 1'b0);
        chk("reset ready4", if4.tx_ready, 1'b1);
        chk("reset tx2", tx2, 1'b1);
        chk("reset busy2", busy2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            sel2 = vecs[i].sel2;
            start($sformatf("vec%0d", i), vecs[i].data, vecs[i].alt);
            run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].sel2 ? 2 : 4, 1'b0, -1);
            idle($sformatf("vec%0d", i));
        end
        sel2 = 1'b0;

        start("b2b0", 8'h00, 8'h00);
        run_frame("b2b0", 10'b1_00000000_0, 4, 1'b0, -1);
        start("b2b1", 8'hFF, 8'h00);
        run_frame("b2b1", 10'b1_11111111_0, 4, 1'b0, -1);
        idle("b2b");

        start("ignore", 8'h81, 8'h00);
        run_frame("ignore", 10'b1_10000001_0, 4, 1'b1, -1);
        for (int n = 0; n < 4; n++) idle("ignore_after");

        start("abort", 8'hA5, 8'h00);
        run_frame("abort", 10'b1_10100101_0, 4, 1'b0, 17);
        #1 reset = 1'b0;
        #1;
        chk("abort tx", tx4, 1'b1);
        chk("abort busy", busy4, 1'b0);
        chk("abort ready", if4.tx_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        idle("post_reset");
        start("fresh", 8'h55, 8'h00);
        run_frame("fresh", 10'b1_01010101_0, 4, 1'b0, -1);
        idle("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rolfmobile99_uart_tx.md
Name: rolfmobile99_uart_tx

Overview:
- Serial transmitter for the 8-bit-pin tiny user project top.
- Accepts a parallel byte over a valid/ready handshake and shifts it out as one 8N1 UART frame on a single output pin.
- The top routes `tx` to a spare `io_out` bit and `tx_data` / `tx_valid` from `io_in`.
- This block is the outbound (driver) end of the pin interface that the top's combinational input logic consumes.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit period. Legal range 2..255; values outside this range are illegal.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- tx_data  input  8  byte to send; sampled only on an accepted handshake.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset state (reset=0, takes effect immediately, no clock needed):
  - state=IDLE, tx=1, busy=0, tx_ready=1.
  - Shift register and counters cleared.
- Registered outputs: tx and busy are registers; tx_ready is combinational from registered state/counters only, never from tx_valid.
- Handshake: a transfer occurs on a rising edge where tx_valid=1 and tx_ready=1. tx_data is latched into the shift register on that edge.
- States and transitions:
  - IDLE: tx=1, busy=0, tx_ready=1. On accept → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. 3-bit bit index counts 0..7; after bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles → IDLE, or → START if a byte is accepted in the last STOP cycle.
- Timing:
  - tx falls on the first edge after the accepting edge, i.e. 1-cycle latency.
  - A frame occupies exactly 10*CLKS_PER_BIT cycles.
  - busy is 1 from the first START cycle through the last STOP cycle.
- Bit-period counter: width clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Back-to-back frames:
  - tx_ready is also 1 during the final cycle of STOP.
  - An accept in that cycle starts the next START immediately, with zero idle cycles between frames; busy stays 1 across the boundary.
- Boundary conditions:
  - tx_valid while tx_ready=0 is ignored, with no side effects; the producer must hold tx_valid until ready.
  - Changes to tx_data after the accept edge do not affect the frame in flight.
  - tx_valid=0 in the last STOP cycle → IDLE, tx stays 1.
  - Reset asserted mid-frame aborts the frame: tx=1 immediately and all state cleared. After reset deasserts, the first accept starts a fresh frame.
  - No glitches on tx; the line changes only on clock edges (or async reset).

Test Plan:
- CLKS_PER_BIT=4, send 0xA5 from IDLE → accept edge at cycle 0; over cycles 1..40 tx = 0, 1,0,1,0,0,1,0,1, 1 (each value held 4 cycles); busy=1 for cycles 1..40; tx_ready=1 again at cycle 40.
- Back-to-back: tx_valid held high with 0x00 then 0xFF → second accept in cycle 40; tx = 0 for cycles 41..44; no idle gap; busy never drops between frames; second frame data bits all 1; both frames 80 cycles total.
- Pulse tx_valid with 0x3C during cycles 10..20 of a frame carrying 0x81 → no accept, tx_ready=0; the frame still shows bits 1,0,0,0,0,0,0,1, and no second frame follows.
- Drive reset=0 at cycle 17 mid-frame → tx=1, busy=0, tx_ready=1 immediately without a clock edge; after release, sending 0x55 produces a clean 40-cycle frame.
- Change tx_data from 0x0F to 0xF0 on the cycle after accept → transmitted data bits are 1,1,1,1,0,0,0,0 (0x0F).
- CLKS_PER_BIT=2, send 0x01 → frame is 20 cycles: start bit 2 cycles, bit0=1 for 2 cycles, bits 1..7 = 0, stop bit 1.
